// File: rtl/stopwatch_counter.sv
// Stopwatch time base: MM:SS counter with run/pause FSM and a no-carry adjust mode.
// Optional blink mask for the field being adjusted: define STOPWATCH_BLINK_EN.
module stopwatch_counter #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause,
    input  logic       clear,
    input  logic       adj,
    input  logic       sel,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       blank_min,
    output logic       blank_sec
);

    localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
    localparam logic [5:0] MAX_SEC_V = 6'(MAX_SEC);

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t     state_reg;
    logic       running_reg;
    logic [5:0] min_reg;
    logic [5:0] sec_reg;
    logic       toggle_pause;

    assign toggle_pause = pause & ~adj;

    // Every branch reads state_reg as held at the start of the cycle, so a tick
    // coincident with pause uses the old run state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= PAUSED;
            running_reg <= 1'b0;
            min_reg     <= '0;
            sec_reg     <= '0;
        end else begin
            if (toggle_pause) begin
                state_reg   <= (state_reg == RUN) ? PAUSED : RUN;
                running_reg <= (state_reg != RUN);
            end

            if (clear) begin
                min_reg <= '0;
                sec_reg <= '0;
            end else if (adj) begin
                if (tick_2hz) begin
                    if (sel)
                        sec_reg <= (sec_reg >= MAX_SEC_V) ? 6'd0 : sec_reg + 6'd1;
                    else
                        min_reg <= (min_reg >= MAX_MIN_V) ? 6'd0 : min_reg + 6'd1;
                end
            end else if (state_reg == RUN && tick_1hz) begin
                if (sec_reg >= MAX_SEC_V) begin
                    sec_reg <= '0;
                    min_reg <= (min_reg >= MAX_MIN_V) ? 6'd0 : min_reg + 6'd1;
                end else begin
                    sec_reg <= sec_reg + 6'd1;
                end
            end
        end
    end

    assign minutes = min_reg;
    assign seconds = sec_reg;
    assign running = running_reg;

`ifdef STOPWATCH_BLINK_EN
    logic toggle_reg;
    logic toggle_next;
    logic blank_min_reg;
    logic blank_sec_reg;

    always_comb begin
        toggle_next = toggle_reg;
        if (!adj)
            toggle_next = 1'b0;
        else if (tick_2hz)
            toggle_next = ~toggle_reg;
    end

    // Masks are registered from the new toggle value so they line up with the
    // field update they accompany.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_reg    <= 1'b0;
            blank_min_reg <= 1'b0;
            blank_sec_reg <= 1'b0;
        end else begin
            toggle_reg    <= toggle_next;
            blank_sec_reg <= adj & sel & toggle_next;
            blank_min_reg <= adj & ~sel & toggle_next;
        end
    end

    assign blank_min = blank_min_reg;
    assign blank_sec = blank_sec_reg;
`else
    assign blank_min = 1'b0;
    assign blank_sec = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomised and directed bench for stopwatch_counter against a time-arithmetic model.
module tb_stopwatch_counter;

    localparam int MAX_MIN = 59;
    localparam int MAX_SEC = 59;
    localparam int SPAN    = (MAX_MIN + 1) * (MAX_SEC + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, pause = 1'b0, clear = 1'b0;
    logic       adj = 1'b0, sel = 1'b0;
    logic [5:0] minutes, seconds;
    logic       running, blank_min, blank_sec;

    int checks = 0;
    int failures = 0;

    stopwatch_counter #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause(pause), .clear(clear), .adj(adj), .sel(sel),
        .minutes(minutes), .seconds(seconds), .running(running),
        .blank_min(blank_min), .blank_sec(blank_sec)
    );

    always #5 clk = ~clk;

    // Model: elapsed time as one integer in normal mode, independent fields in adjust.
    int m_min = 0, m_sec = 0, m_tog = 0, m_bmin = 0, m_bsec = 0;
    bit m_run = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int total, nmin, nsec, ntog;
        if (!rst_n) begin
            m_min <= 0; m_sec <= 0; m_run <= 1'b0;
            m_tog <= 0; m_bmin <= 0; m_bsec <= 0;
        end else begin
            nmin = m_min;
            nsec = m_sec;
            if (clear) begin
                nmin = 0; nsec = 0;
            end else if (adj) begin
                if (tick_2hz) begin
                    if (sel) nsec = (m_sec + 1) % (MAX_SEC + 1);
                    else     nmin = (m_min + 1) % (MAX_MIN + 1);
                end
            end else if (m_run && tick_1hz) begin
                total = (m_min * (MAX_SEC + 1) + m_sec + 1) % SPAN;
                nmin  = total / (MAX_SEC + 1);
                nsec  = total % (MAX_SEC + 1);
            end
            if (pause && !adj) m_run <= !m_run;
            m_min <= nmin;
            m_sec <= nsec;
            ntog = adj ? (tick_2hz ? 1 - m_tog : m_tog) : 0;
            m_tog <= ntog;
`ifdef STOPWATCH_BLINK_EN
            m_bsec <= (adj && sel) ? ntog : 0;
            m_bmin <= (adj && !sel) ? ntog : 0;
`else
            m_bsec <= 0;
            m_bmin <= 0;
`endif
        end
    end

    always @(negedge clk) begin
        checks++;
        if (int'(minutes) != m_min || int'(seconds) != m_sec || running != m_run ||
            int'(blank_min) != m_bmin || int'(blank_sec) != m_bsec) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got %0d:%0d run=%0b bm=%0b bs=%0b exp %0d:%0d run=%0b bm=%0d bs=%0d",
                     $time, minutes, seconds, running, blank_min, blank_sec,
                     m_min, m_sec, m_run, m_bmin, m_bsec);
        end
    end

    task automatic step(input bit t1, input bit t2, input bit p, input bit c,
                        input bit a, input bit s);
        @(negedge clk);
        tick_1hz = t1; tick_2hz = t2; pause = p; clear = c; adj = a; sel = s;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else
            $display("check %s = %0d", name, got);
    endtask

    task automatic chk_time(input string name, input int mm, input int ss, input int run);
        chk({name, "_min"}, int'(minutes), mm);
        chk({name, "_sec"}, int'(seconds), ss);
        chk({name, "_run"}, int'(running), run);
    endtask

    task automatic adjust_n(input bit s, input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1, s);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_time("reset", 0, 0, 0);
        chk("reset_blank", int'({blank_min, blank_sec}), 0);
        rst_n = 1'b1;

        // Start, count five, pause, ticks ignored.
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_time("run5", 0, 5, 1);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_time("paused", 0, 5, 0);

        // Preload 59:59 via adjust, resume and wrap to 00:00.
        step(0, 0, 0, 1, 0, 0);
        adjust_n(0, 59);
        adjust_n(1, 59);
        step(0, 0, 0, 0, 1, 1);
        chk_time("pre5959", 59, 59, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_time("wrap0000", 0, 0, 1);
        adjust_n(1, 59);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_time("carry0100", 1, 0, 1);

        // Seconds adjust across wrap, 1 Hz ticks ignored, blink pattern.
        adjust_n(1, 58);
        step(1, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        chk_time("adj_s59", 1, 59, 1);
`ifdef STOPWATCH_BLINK_EN
        chk("blink_sec_on", int'(blank_sec), 1);
`else
        chk("blink_sec_off", int'(blank_sec), 0);
`endif
        chk("blink_min_a", int'(blank_min), 0);
        step(1, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        chk_time("adj_s00", 1, 0, 1);
        chk("blink_sec_b", int'(blank_sec), 0);
        chk("blink_min_b", int'(blank_min), 0);
        step(1, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        chk_time("adj_s01", 1, 1, 1);

        // Minutes adjust wraps with no effect on seconds; pause ignored in adjust.
        adjust_n(0, 58);
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk_time("adj_m00", 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_time("resume", 0, 2, 1);

        // Clear beats tick at 12:34, state kept.
        step(0, 0, 0, 1, 0, 0);
        adjust_n(0, 12);
        adjust_n(1, 34);
        step(0, 0, 0, 0, 0, 0);
        chk_time("pre1234", 12, 34, 1);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_time("clear", 0, 0, 1);

        // Asynchronous reset mid-count.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_time("pre_rst", 0, 3, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_time("async_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic checked by the per-cycle compare process.
        for (int i = 0; i < 4000; i++) begin
            bit a, s;
            a = adj; s = sel;
            if ($urandom_range(0, 19) == 0) a = ~a;
            if ($urandom_range(0, 7) == 0) s = ~s;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, a, s);
        end
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
